// File: rtl/full_adder.sv
// rtl/full_adder.sv - one-bit full adder cell used by the multiplier reduction array
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/mult_3x3_array.sv
// rtl/mult_3x3_array.sv - combinational 3x3 unsigned array multiplier built from full_adder cells
module mult_3x3_array (
    input  logic [2:0] a_i,
    input  logic [2:0] b_i,
    output logic [5:0] p_o
);

    localparam int OP_W = 3;

    logic [OP_W-1:0][OP_W-1:0] pp;
    logic s11, s21;
    logic c10, c11, c20, c21, c30;
    logic p1, p2, p3, p4, p5;

    // pp[i][j] carries weight i+j
    always_comb begin
        pp = '0;
        for (int i = 0; i < OP_W; i++) begin
            for (int j = 0; j < OP_W; j++) begin
                pp[i][j] = a_i[i] & b_i[j];
            end
        end
    end

    // First row: half adders (cin tied low) at weights 1 and 2
    full_adder u_fa10 (.a(pp[1][0]), .b(pp[0][1]), .cin(1'b0), .s(p1),  .cout(c10));
    full_adder u_fa11 (.a(pp[2][0]), .b(pp[1][1]), .cin(1'b0), .s(s11), .cout(c11));

    // Second row folds in the b2 partial products
    full_adder u_fa20 (.a(s11),      .b(pp[0][2]), .cin(c10), .s(p2),  .cout(c20));
    full_adder u_fa21 (.a(pp[2][1]), .b(pp[1][2]), .cin(c11), .s(s21), .cout(c21));

    // Final ripple row resolves weights 3..5
    full_adder u_fa30 (.a(s21),      .b(c20),      .cin(1'b0), .s(p3), .cout(c30));
    full_adder u_fa40 (.a(pp[2][2]), .b(c21),      .cin(c30),  .s(p4), .cout(p5));

    assign p_o = {p5, p4, p3, p2, p1, pp[0][0]};

endmodule

// File: rtl/mult_3x3.sv
// rtl/mult_3x3.sv - 3x3 unsigned multiplier with a single registered output stage and valid flag
module mult_3x3 (
    input  logic clk,
    input  logic rst_n,
    output logic p0,
    output logic p1,
    output logic p2,
    output logic p3,
    output logic p4,
    output logic p5,
    input  logic a0,
    input  logic a1,
    input  logic a2,
    input  logic b0,
    input  logic b1,
    input  logic b2,
    input  logic in_valid,
    output logic out_valid
);

    localparam int OP_W   = 3;
    localparam int PROD_W = 6;

    logic [OP_W-1:0]   op_a;
    logic [OP_W-1:0]   op_b;
    logic [PROD_W-1:0] prod;
    logic [PROD_W-1:0] p_d, p_q;
    logic              valid_d, valid_q;

    assign op_a = {a2, a1, a0};
    assign op_b = {b2, b1, b0};

    mult_3x3_array u_array (
        .a_i (op_a),
        .b_i (op_b),
        .p_o (prod)
    );

    // Product is only selected when in_valid is high, so idle operands never reach the register
    always_comb begin
        p_d     = p_q;
        valid_d = 1'b0;
        if (in_valid) begin
            p_d     = prod;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            p_q     <= '0;
            valid_q <= 1'b0;
        end else begin
            p_q     <= p_d;
            valid_q <= valid_d;
        end
    end

    assign {p5, p4, p3, p2, p1, p0} = p_q;
    assign out_valid                = valid_q;

endmodule

// File: tb/tb_mult_3x3.sv
// tb/tb_mult_3x3.sv - randomized and directed self-checking bench for mult_3x3
module tb_mult_3x3;

    logic       clk;
    logic       rst_n;
    logic [2:0] a;
    logic [2:0] b;
    logic       in_valid;
    logic [5:0] p;
    logic       out_valid;

    int total;
    int bad;

    int  exp_p;
    bit  exp_v;
    bit  model_ok;
    int  vcount;

    mult_3x3 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .p0        (p[0]),
        .p1        (p[1]),
        .p2        (p[2]),
        .p3        (p[3]),
        .p4        (p[4]),
        .p5        (p[5]),
        .a0        (a[0]),
        .a1        (a[1]),
        .a2        (a[2]),
        .b0        (b[0]),
        .b1        (b[1]),
        .b2        (b[2]),
        .in_valid  (in_valid),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: the register holds the last accepted A*B; valid mirrors the accepting edge
    always @(posedge clk) begin
        if (!rst_n) begin
            exp_p = 0;
            exp_v = 1'b0;
        end else if (in_valid) begin
            exp_p = int'(a) * int'(b);
            exp_v = 1'b1;
        end else begin
            exp_v = 1'b0;
        end
        model_ok = 1'b1;
    end

    always @(negedge clk) begin
        if (model_ok) begin
            total++;
            if (int'(p) != exp_p || out_valid != exp_v) begin
                bad++;
                $display("FAIL model t=%0t p=%0d v=%0b required p=%0d v=%0b", $time, p, out_valid, exp_p, exp_v);
            end
            if (out_valid) vcount++;
        end
    end

    task automatic cycle(input int av, input int bv, input bit v, input bit r);
        @(negedge clk);
        #1;
        a        = 3'(av);
        b        = 3'(bv);
        in_valid = v;
        rst_n    = r;
    endtask

    task automatic lit(input string name, input int ep, input bit ev);
        total++;
        if (int'(p) != ep || out_valid != ev) begin
            bad++;
            $display("FAIL %s p=%0d v=%0b required p=%0d v=%0b", name, p, out_valid, ep, ev);
        end
    endtask

    int seq_a [5] = '{3, 6, 2, 7, 4};
    int seq_b [5] = '{5, 1, 7, 3, 4};
    int seq_p [5] = '{15, 6, 14, 21, 16};

    initial begin
        total    = 0;
        bad      = 0;
        model_ok = 1'b0;
        vcount   = 0;
        exp_p    = 0;
        exp_v    = 1'b0;
        rst_n    = 1'b0;
        a        = 3'd0;
        b        = 3'd0;
        in_valid = 1'b1;

        cycle(0, 0, 1'b1, 1'b0);
        cycle(0, 0, 1'b1, 1);
        lit("reset_state", 0, 1'b0);
        cycle(0, 0, 1'b0, 1'b1);
        lit("zero_times_zero", 0, 1'b1);

        for (int k = 0; k < 5; k++) begin
            cycle(seq_a[k], seq_b[k], 1'b1, 1'b1);
            if (k > 0) lit("seq_b2b", seq_p[k-1], 1'b1);
        end
        cycle(7, 7, 1'b1, 1'b1);
        lit("seq_b2b_last", 16, 1'b1);
        cycle(7, 0, 1'b1, 1'b1);
        lit("max_7x7", 49, 1'b1);
        cycle(0, 0, 1'b0, 1'b1);
        lit("a7_b0", 0, 1'b1);

        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 8; j++) begin
                cycle(i, j, 1'b1, 1'b1);
            end
        end
        cycle(0, 0, 1'b0, 1'b1);
        lit("sweep_last", 49, 1'b1);

        vcount = 0;
        cycle(5, 5, 1'b1, 1'b1);
        for (int k = 0; k < 3; k++) begin
            cycle($urandom_range(0, 7), $urandom_range(0, 7), 1'b0, 1'b1);
            lit(k == 0 ? "hold_first" : "hold_idle", 25, k == 0);
        end
        cycle(0, 0, 1'b0, 1'b1);
        lit("hold_end", 25, 1'b0);
        total++;
        if (vcount != 1) begin
            bad++;
            $display("FAIL hold_pulses count=%0d required=1", vcount);
        end

        cycle(6, 6, 1'b1, 1'b0);
        cycle(6, 6, 1'b0, 1'b1);
        lit("reset_drops_36", 0, 1'b0);
        cycle(3, 2, 1'b1, 1'b1);
        lit("post_reset_idle", 0, 1'b0);
        cycle(0, 0, 1'b0, 1'b1);
        lit("post_reset_first", 6, 1'b1);

        for (int k = 0; k < 400; k++) begin
            cycle($urandom_range(0, 7), $urandom_range(0, 7),
                  ($urandom_range(0, 3) != 0), ($urandom_range(0, 31) != 0));
        end
        cycle(0, 0, 1'b0, 1'b1);
        cycle(0, 0, 1'b0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
